// File: rtl/button_debouncer.sv
// Push-button conditioner: polarity normalisation, 2-flop synchroniser, debounce FSM
// and registered press / release / long-press strobes for the LED sequencers.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES   = 2_000_000,
    parameter int LONG_PRESS_CYCLES = 100_000_000,
    parameter bit BTN_ACTIVE_LOW    = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_in,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_press_pulse,
    output logic held_long
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int HW = $clog2(LONG_PRESS_CYCLES + 1);

    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_PRESS_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_PRESS_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_t;

    state_t        state;
    logic [DW-1:0] db_cnt;
    logic [HW-1:0] hold_cnt;
    logic          btn_norm;
    logic          sync_meta;
    logic          sync_out;
    logic          holding;
    logic          hold_hit;

    assign btn_norm = btn_in ^ BTN_ACTIVE_LOW;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta <= 1'b0;
            sync_out  <= 1'b0;
        end else begin
            sync_meta <= btn_norm;
            sync_out  <= sync_meta;
        end
    end

    // The hold counter runs in both pressed states so a release bounce cannot delay the long press.
    assign holding  = (state == PRESSED) || (state == RELEASE_WAIT);
    assign hold_hit = holding && (hold_cnt == HOLD_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            db_cnt           <= '0;
            hold_cnt         <= '0;
            btn_level        <= 1'b0;
            press_pulse      <= 1'b0;
            release_pulse    <= 1'b0;
            long_press_pulse <= 1'b0;
            held_long        <= 1'b0;
        end else begin
            press_pulse      <= 1'b0;
            release_pulse    <= 1'b0;
            long_press_pulse <= 1'b0;

            if (holding && (hold_cnt != HOLD_MAX)) begin
                hold_cnt <= hold_cnt + HW'(1);
            end
            if (hold_hit) begin
                long_press_pulse <= 1'b1;
                held_long        <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (sync_out) begin
                        state  <= PRESS_WAIT;
                        db_cnt <= '0;
                    end
                end

                PRESS_WAIT: begin
                    if (!sync_out) begin
                        state  <= IDLE;
                        db_cnt <= '0;
                    end else if (db_cnt == DB_LAST) begin
                        state       <= PRESSED;
                        btn_level   <= 1'b1;
                        press_pulse <= 1'b1;
                        hold_cnt    <= '0;
                    end else begin
                        db_cnt <= db_cnt + DW'(1);
                    end
                end

                PRESSED: begin
                    if (!sync_out) begin
                        state  <= RELEASE_WAIT;
                        db_cnt <= '0;
                    end
                end

                RELEASE_WAIT: begin
                    if (sync_out) begin
                        state <= PRESSED;
                    end else if (db_cnt == DB_LAST) begin
                        // A release landing on the long-press edge is held off one cycle so strobes never overlap.
                        if (!hold_hit) begin
                            state         <= IDLE;
                            btn_level     <= 1'b0;
                            held_long     <= 1'b0;
                            release_pulse <= 1'b1;
                            hold_cnt      <= '0;
                        end
                    end else begin
                        db_cnt <= db_cnt + DW'(1);
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_button_debouncer.sv
// Bench for button_debouncer: an active-high and an active-low instance see the same
// pressed/released stimulus and are compared every cycle against a run-length model.
module tb_button_debouncer;

   localparam int DB = 4;
   localparam int LP = 10;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic btn = 1'b0;
   logic btn_al;

   logic btn_level, press_pulse, release_pulse, long_press_pulse, held_long;
   logic al_level, al_press, al_release, al_long, al_held;
   logic [4:0] obs, obs_al;

   int checks = 0;
   int errors = 0;

   // Reference model state: sample history, accepted level, run length of disagreeing samples, hold age
   logic m_hist0, m_hist1;
   logic m_level, m_held, m_press, m_release, m_long;
   int   m_run, m_age;

   always #5 clk = ~clk;

   assign btn_al = ~btn;
   assign obs    = {btn_level, press_pulse, release_pulse, long_press_pulse, held_long};
   assign obs_al = {al_level, al_press, al_release, al_long, al_held};

   button_debouncer #(.DEBOUNCE_CYCLES(DB), .LONG_PRESS_CYCLES(LP), .BTN_ACTIVE_LOW(1'b0)) dut (
      .clk(clk), .rst_n(rst_n), .btn_in(btn),
      .btn_level(btn_level), .press_pulse(press_pulse), .release_pulse(release_pulse),
      .long_press_pulse(long_press_pulse), .held_long(held_long)
   );

   button_debouncer #(.DEBOUNCE_CYCLES(DB), .LONG_PRESS_CYCLES(LP), .BTN_ACTIVE_LOW(1'b1)) dut_al (
      .clk(clk), .rst_n(rst_n), .btn_in(btn_al),
      .btn_level(al_level), .press_pulse(al_press), .release_pulse(al_release),
      .long_press_pulse(al_long), .held_long(al_held)
   );

   function automatic logic [4:0] exp_vec();
      return {m_level, m_press, m_release, m_long, m_held};
   endfunction

   task automatic model_clear();
      m_hist0 = 1'b0; m_hist1 = 1'b0;
      m_level = 1'b0; m_held = 1'b0;
      m_press = 1'b0; m_release = 1'b0; m_long = 1'b0;
      m_run = 0; m_age = 0;
   endtask

   // Drive one pressed/released value for a clock edge, advance the model, sample 1 ns later
   task automatic step(input logic b);
      logic s;
      btn = b;
      @(posedge clk);
      s = m_hist1;
      m_hist1 = m_hist0;
      m_hist0 = b;
      m_press = 1'b0; m_release = 1'b0; m_long = 1'b0;
      if (m_level && (m_age < LP)) begin
         m_age++;
         if (m_age == LP) begin
            m_long = 1'b1;
            m_held = 1'b1;
         end
      end
      if (s != m_level) m_run++;
      else m_run = 0;
      if ((m_run >= DB + 1) && !m_long) begin
         if (!m_level) begin
            m_level = 1'b1; m_press = 1'b1; m_age = 0;
         end else begin
            m_level = 1'b0; m_release = 1'b1; m_held = 1'b0;
         end
         m_run = 0;
      end
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      btn = 1'b1;
      model_clear();
      repeat (3) begin
         @(posedge clk);
         #1;
         checks++;
         if ({obs, obs_al} !== 10'b0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %b / %b, expected all zero", obs, obs_al);
         end
      end
      btn = 1'b0;
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         step(1'b0);
         checks++;
         if ({obs, obs_al} !== {exp_vec(), exp_vec()}) begin
            errors++;
            $display("[TB] FAIL reset_idle k=%0d: got %b / %b, expected %b", k, obs, obs_al, exp_vec());
         end
      end
   endtask

   task automatic test_clean_press_long();
      int press_edge = -1, long_edge = -1, rel_edge = -1, other = 0;
      for (int k = 0; k < 30; k++) begin
         step(1'b1);
         checks++;
         if ({obs, obs_al} !== {exp_vec(), exp_vec()}) begin
            errors++;
            $display("[TB] FAIL clean_press k=%0d: got %b / %b, expected %b", k, obs, obs_al, exp_vec());
         end
         if (press_pulse) press_edge = k;
         if (long_press_pulse) long_edge = k;
         if (release_pulse || (long_press_pulse && k != 16) || (press_pulse && k != 6)) other++;
      end
      checks++;
      if (press_edge !== 6) begin
         errors++;
         $display("[TB] FAIL clean_press_edge: got %0d, expected 6", press_edge);
      end
      checks++;
      if (long_edge !== 16) begin
         errors++;
         $display("[TB] FAIL long_press_edge: got %0d, expected 16", long_edge);
      end
      checks++;
      if (other !== 0) begin
         errors++;
         $display("[TB] FAIL clean_press_extra_strobes: got %0d, expected 0", other);
      end
      checks++;
      if (held_long !== 1'b1) begin
         errors++;
         $display("[TB] FAIL held_long_after: got %b, expected 1", held_long);
      end
      for (int k = 0; k < 10; k++) begin
         step(1'b0);
         checks++;
         if ({obs, obs_al} !== {exp_vec(), exp_vec()}) begin
            errors++;
            $display("[TB] FAIL clean_release k=%0d: got %b / %b, expected %b", k, obs, obs_al, exp_vec());
         end
         if (release_pulse) rel_edge = k;
      end
      checks++;
      if (rel_edge !== 6) begin
         errors++;
         $display("[TB] FAIL release_edge: got %0d, expected 6", rel_edge);
      end
      checks++;
      if ({btn_level, held_long} !== 2'b00) begin
         errors++;
         $display("[TB] FAIL after_release: got %b, expected 00", {btn_level, held_long});
      end
   endtask

   task automatic test_press_bounce();
      logic [5:0] pat;
      int press_edge = -1, press_cnt = 0, early = 0;
      pat = 6'b010101;
      for (int k = 0; k < 18; k++) begin
         step(k < 6 ? pat[k] : 1'b1);
         checks++;
         if ({obs, obs_al} !== {exp_vec(), exp_vec()}) begin
            errors++;
            $display("[TB] FAIL press_bounce k=%0d: got %b / %b, expected %b", k, obs, obs_al, exp_vec());
         end
         if (press_pulse) begin press_edge = k; press_cnt++; end
         if (btn_level && press_edge < 0) early++;
      end
      checks++;
      if (press_cnt !== 1 || press_edge !== 12) begin
         errors++;
         $display("[TB] FAIL press_bounce_pulse: got count %0d edge %0d, expected 1 at 12", press_cnt, press_edge);
      end
      checks++;
      if (early !== 0) begin
         errors++;
         $display("[TB] FAIL press_bounce_early_level: got %0d, expected 0", early);
      end
      repeat (10) step(1'b0);
   endtask

   task automatic test_release_bounce();
      logic [12:0] pat;
      int long_edge = -1, rel_edge = -1, rel_cnt = 0;
      pat = 13'b0_1110_0111_1111;
      for (int k = 0; k < 30; k++) begin
         step(k < 12 ? pat[k] : 1'b0);
         checks++;
         if ({obs, obs_al} !== {exp_vec(), exp_vec()}) begin
            errors++;
            $display("[TB] FAIL release_bounce k=%0d: got %b / %b, expected %b", k, obs, obs_al, exp_vec());
         end
         if (long_press_pulse) long_edge = k;
         if (release_pulse) begin rel_edge = k; rel_cnt++; end
      end
      checks++;
      if (long_edge !== 16) begin
         errors++;
         $display("[TB] FAIL release_bounce_long_edge: got %0d, expected 16", long_edge);
      end
      checks++;
      if (rel_cnt !== 1 || rel_edge !== 18) begin
         errors++;
         $display("[TB] FAIL release_bounce_pulse: got count %0d edge %0d, expected 1 at 18", rel_cnt, rel_edge);
      end
   endtask

   task automatic test_short_tap();
      int seen = 0;
      for (int k = 0; k < 14; k++) begin
         step(k < 3 ? 1'b1 : 1'b0);
         checks++;
         if ({obs, obs_al} !== {exp_vec(), exp_vec()}) begin
            errors++;
            $display("[TB] FAIL short_tap k=%0d: got %b / %b, expected %b", k, obs, obs_al, exp_vec());
         end
         if (btn_level || press_pulse || release_pulse) seen++;
      end
      checks++;
      if (seen !== 0) begin
         errors++;
         $display("[TB] FAIL short_tap_activity: got %0d, expected 0", seen);
      end
   endtask

   task automatic test_reset_mid_hold();
      int press_edge = -1, rel_seen = 0;
      repeat (9) step(1'b1);
      checks++;
      if (btn_level !== 1'b1) begin
         errors++;
         $display("[TB] FAIL mid_hold_pressed: got %b, expected 1", btn_level);
      end
      #2;
      rst_n = 1'b0;
      model_clear();
      #1;
      checks++;
      if ({obs, obs_al} !== 10'b0) begin
         errors++;
         $display("[TB] FAIL mid_hold_reset_now: got %b / %b, expected all zero", obs, obs_al);
      end
      repeat (2) begin
         @(posedge clk);
         #1;
         if (release_pulse || al_release) rel_seen++;
      end
      checks++;
      if (rel_seen !== 0) begin
         errors++;
         $display("[TB] FAIL mid_hold_release: got %0d, expected 0", rel_seen);
      end
      rst_n = 1'b1;
      for (int k = 0; k < 10; k++) begin
         step(1'b1);
         checks++;
         if ({obs, obs_al} !== {exp_vec(), exp_vec()}) begin
            errors++;
            $display("[TB] FAIL mid_hold_repress k=%0d: got %b / %b, expected %b", k, obs, obs_al, exp_vec());
         end
         if (press_pulse && al_press) press_edge = k;
      end
      checks++;
      if (press_edge !== 6) begin
         errors++;
         $display("[TB] FAIL mid_hold_press_edge: got %0d, expected 6", press_edge);
      end
      repeat (10) step(1'b0);
   endtask

   task automatic test_random();
      int cyc = 0;
      logic lvl = 1'b0;
      while (cyc < 600) begin
         int len;
         len = (($urandom % 3) == 0) ? int'($urandom_range(1, 3)) : int'($urandom_range(4, 18));
         lvl = ~lvl;
         for (int k = 0; k < len; k++) begin
            step(lvl);
            cyc++;
            checks++;
            if ({obs, obs_al} !== {exp_vec(), exp_vec()}) begin
               errors++;
               $display("[TB] FAIL random cyc=%0d: got %b / %b, expected %b", cyc, obs, obs_al, exp_vec());
            end
         end
      end
   endtask

   initial begin
      model_clear();
      test_reset();
      test_clean_press_long();
      test_press_bounce();
      test_release_bounce();
      test_short_tap();
      test_reset_mid_hold();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
